// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and FSM state type for the regfile write-back arbiter.
package regfile_wb_arbiter_pkg;

  localparam int unsigned RegAddrBusW = 5;
  localparam int unsigned RegBusW     = 32;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  typedef enum logic [1:0] {
    WbIdle  = 2'd0,
    WbHold  = 2'd1,
    WbForce = 2'd2
  } wb_state_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of pipeline, multi-cycle unit, decode-check and regfile write signals.
interface regfile_wb_arbiter_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  logic              a_we;
  logic [ADDR_W-1:0] a_waddr;
  logic [DATA_W-1:0] a_wdata;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_waddr;
  logic [DATA_W-1:0] b_wdata;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_waddr;
  logic [ADDR_W-1:0] chk_raddr1;
  logic [ADDR_W-1:0] chk_raddr2;
  logic [ADDR_W-1:0] chk_waddr;
  logic              hazard;
  logic              wb_stall;
  logic              err;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  modport master (
    output a_we, a_waddr, a_wdata, b_valid, b_waddr, b_wdata,
           iss_valid, iss_waddr, chk_raddr1, chk_raddr2, chk_waddr,
    input  b_ready, hazard, wb_stall, err, we, waddr, wdata
  );

  modport slave (
    input  a_we, a_waddr, a_wdata, b_valid, b_waddr, b_wdata,
           iss_valid, iss_waddr, chk_raddr1, chk_raddr2, chk_waddr,
    output b_ready, hazard, wb_stall, err, we, waddr, wdata
  );
endinterface

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// wb_scoreboard: pending-write bits for registers owed by the multi-cycle unit,
// with a three-port combinational hazard lookup. Register 0 is never pending.
module wb_scoreboard #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  input  logic [ADDR_W-1:0] waddr,
  output logic              hazard
);
  localparam int unsigned NREG = 1 << ADDR_W;

  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;

  // Clear is applied before set so a same-edge set/clear leaves the bit set.
  always_comb begin
    pending_nxt = pending;
    if (clr_en) pending_nxt[clr_addr] = 1'b0;
    if (set_en) pending_nxt[set_addr] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending <= '0;
    else      pending <= pending_nxt;
  end

  assign hazard = pending[raddr1] | pending[raddr2] | pending[waddr];
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the regfile write port between pipeline writeback (A) and a
// multi-cycle unit (B). Optional macro WB_BYPASS_EN lets idle B skip the buffer.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = RegAddrBusW,
  parameter int unsigned DATA_W       = RegBusW,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  wb_state_e         state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;
  logic              buf_ld;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic              err_set;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;
  logic              a_valid;
  logic              b_fire;

  assign a_valid = bus.a_we && (bus.a_waddr != '0);
  assign b_fire  = bus.b_valid && (state == WbIdle);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    buf_ld    = 1'b0;
    wr_en     = WriteDisable;
    wr_addr   = waddr_q;
    wr_data   = wdata_q;
    clr_en    = 1'b0;
    clr_addr  = buf_addr;
    err_set   = 1'b0;
    if (a_valid) begin
      wr_en   = WriteEnable;
      wr_addr = bus.a_waddr;
      wr_data = bus.a_wdata;
    end
    case (state)
      WbIdle: begin
        // A B result for register 0 is accepted and silently dropped.
        if (b_fire && (bus.b_waddr != '0)) begin
`ifdef WB_BYPASS_EN
          if (!a_valid) begin
            wr_en    = WriteEnable;
            wr_addr  = bus.b_waddr;
            wr_data  = bus.b_wdata;
            clr_en   = 1'b1;
            clr_addr = bus.b_waddr;
          end else begin
            buf_ld    = 1'b1;
            state_nxt = WbHold;
            cnt_nxt   = '0;
          end
`else
          buf_ld    = 1'b1;
          state_nxt = WbHold;
          cnt_nxt   = '0;
`endif
        end
      end
      WbHold, WbForce: begin
        if (!a_valid) begin
          wr_en     = WriteEnable;
          wr_addr   = buf_addr;
          wr_data   = buf_data;
          clr_en    = 1'b1;
          state_nxt = WbIdle;
          cnt_nxt   = '0;
        end else if (bus.a_waddr == buf_addr) begin
          // A overwrites the same register anyway: the stale buffered value is dropped.
          clr_en    = 1'b1;
          err_set   = 1'b1;
          state_nxt = WbIdle;
          cnt_nxt   = '0;
        end else if (state == WbHold) begin
          cnt_nxt = cnt + 4'd1;
          if (cnt_nxt == LIMIT) state_nxt = WbForce;
        end
      end
      default: begin
        state_nxt = WbIdle;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= WbIdle;
      cnt      <= '0;
      buf_addr <= '0;
      buf_data <= '0;
      we_q     <= WriteDisable;
      waddr_q  <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      we_q  <= wr_en;
      if (buf_ld) begin
        buf_addr <= bus.b_waddr;
        buf_data <= bus.b_wdata;
      end
      if (wr_en) begin
        waddr_q <= wr_addr;
        wdata_q <= wr_data;
      end
      if (err_set) err_q <= 1'b1;
    end
  end

  wb_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set_en  (bus.iss_valid),
    .set_addr(bus.iss_waddr),
    .clr_en  (clr_en),
    .clr_addr(clr_addr),
    .raddr1  (bus.chk_raddr1),
    .raddr2  (bus.chk_raddr2),
    .waddr   (bus.chk_waddr),
    .hazard  (bus.hazard)
  );

  assign bus.b_ready  = (state == WbIdle);
  assign bus.wb_stall = (state == WbForce);
  assign bus.err      = err_q;
  assign bus.we       = we_q;
  assign bus.waddr    = waddr_q;
  assign bus.wdata    = wdata_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (STARVE_LIMIT=4).
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  regfile_wb_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  regfile_wb_arbiter #(
    .ADDR_W(5),
    .DATA_W(32),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Protocol monitor: the pipeline must never write while stalled.
  always @(posedge clk) begin
    if (rst && bus.wb_stall && bus.a_we && (bus.a_waddr != 5'd0)) begin
      errors++;
      $display("FAIL protocol: a_we=1 while wb_stall=1");
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.a_we = 0; bus.a_waddr = 0; bus.a_wdata = 0;
    bus.b_valid = 0; bus.b_waddr = 0; bus.b_wdata = 0;
    bus.iss_valid = 0; bus.iss_waddr = 0;
    bus.chk_raddr1 = 0; bus.chk_raddr2 = 0; bus.chk_waddr = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    tick(); tick();
    checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b want 0", bus.we); end
    checks++; if (bus.waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr: got %0d want 0", bus.waddr); end
    checks++; if (bus.wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h want 0", bus.wdata); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", bus.err); end
    checks++; if (bus.wb_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", bus.wb_stall); end
    checks++; if (bus.b_ready !== 1'b1) begin errors++; $display("FAIL reset_b_ready: got %0b want 1", bus.b_ready); end
    rst = 1;
    tick();
  endtask

  task automatic test_a_write();
    bus.a_we = 1; bus.a_waddr = 5; bus.a_wdata = 32'h1234;
    tick();
    bus.a_we = 0;
    checks++; if (bus.we !== 1'b1 || bus.waddr !== 5'd5 || bus.wdata !== 32'h1234) begin
      errors++; $display("FAIL a_write: got we=%0b waddr=%0d wdata=%h want 1/5/1234", bus.we, bus.waddr, bus.wdata); end
    checks++; if (bus.b_ready !== 1'b1) begin errors++; $display("FAIL a_write_b_ready: got %0b want 1", bus.b_ready); end
    tick();
    checks++; if (bus.we !== 1'b0 || bus.waddr !== 5'd5 || bus.wdata !== 32'h1234) begin
      errors++; $display("FAIL a_idle_hold: got we=%0b waddr=%0d wdata=%h want 0/5/1234", bus.we, bus.waddr, bus.wdata); end
  endtask

  task automatic test_reg_zero();
    bus.a_we = 1; bus.a_waddr = 0; bus.a_wdata = 32'h77;
    bus.iss_valid = 1; bus.iss_waddr = 0;
    tick();
    bus.a_we = 0; bus.iss_valid = 0;
    checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL zero_a: got we=%0b want 0", bus.we); end
    checks++; if (bus.hazard !== 1'b0) begin errors++; $display("FAIL zero_pending: got hazard=%0b want 0", bus.hazard); end
    bus.b_valid = 1; bus.b_waddr = 0; bus.b_wdata = 32'h88;
    tick();
    bus.b_valid = 0;
    tick();
    checks++; if (bus.we !== 1'b0 || bus.b_ready !== 1'b1) begin
      errors++; $display("FAIL zero_b: got we=%0b b_ready=%0b want 0/1", bus.we, bus.b_ready); end
    tick();
    checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL zero_b_late: got we=%0b want 0", bus.we); end
  endtask

  task automatic test_b_write();
    bus.iss_valid = 1; bus.iss_waddr = 7; bus.chk_raddr1 = 7;
    tick();
    bus.iss_valid = 0;
    checks++; if (bus.hazard !== 1'b1) begin errors++; $display("FAIL b_pending_set: got hazard=%0b want 1", bus.hazard); end
    bus.b_valid = 1; bus.b_waddr = 7; bus.b_wdata = 32'hCAFE;
    tick();
    bus.b_valid = 0;
`ifndef WB_BYPASS_EN
    checks++; if (bus.we !== 1'b0 || bus.hazard !== 1'b1 || bus.b_ready !== 1'b0) begin
      errors++; $display("FAIL b_accept: got we=%0b hazard=%0b b_ready=%0b want 0/1/0", bus.we, bus.hazard, bus.b_ready); end
    tick();
`endif
    checks++; if (bus.we !== 1'b1 || bus.waddr !== 5'd7 || bus.wdata !== 32'hCAFE) begin
      errors++; $display("FAIL b_drain: got we=%0b waddr=%0d wdata=%h want 1/7/cafe", bus.we, bus.waddr, bus.wdata); end
    checks++; if (bus.hazard !== 1'b0 || bus.b_ready !== 1'b1) begin
      errors++; $display("FAIL b_pending_clr: got hazard=%0b b_ready=%0b want 0/1", bus.hazard, bus.b_ready); end
    bus.chk_raddr1 = 0;
    tick();
  endtask

  task automatic test_starve();
    bus.a_we = 1; bus.a_waddr = 1; bus.a_wdata = 32'h100;
    bus.b_valid = 1; bus.b_waddr = 12; bus.b_wdata = 32'hBEEF;
    tick();
    bus.b_valid = 0;
    checks++; if (bus.we !== 1'b1 || bus.waddr !== 5'd1 || bus.b_ready !== 1'b0 || bus.wb_stall !== 1'b0) begin
      errors++; $display("FAIL starve_load: got we=%0b waddr=%0d b_ready=%0b stall=%0b want 1/1/0/0",
                         bus.we, bus.waddr, bus.b_ready, bus.wb_stall); end
    for (int i = 0; i < 4; i++) begin
      bus.a_waddr = 5'(2 + i); bus.a_wdata = 32'(32'h200 + i);
      tick();
      checks++; if (bus.we !== 1'b1 || bus.waddr !== 5'(2 + i) || bus.wb_stall !== (i == 3)) begin
        errors++; $display("FAIL starve_a%0d: got we=%0b waddr=%0d stall=%0b want 1/%0d/%0b",
                           i, bus.we, bus.waddr, bus.wb_stall, 2 + i, i == 3); end
    end
    bus.a_we = 0;
    tick();
    checks++; if (bus.we !== 1'b1 || bus.waddr !== 5'd12 || bus.wdata !== 32'hBEEF) begin
      errors++; $display("FAIL starve_drain: got we=%0b waddr=%0d wdata=%h want 1/12/beef", bus.we, bus.waddr, bus.wdata); end
    checks++; if (bus.wb_stall !== 1'b0 || bus.b_ready !== 1'b1) begin
      errors++; $display("FAIL starve_release: got stall=%0b b_ready=%0b want 0/1", bus.wb_stall, bus.b_ready); end
  endtask

  task automatic test_waw();
    bus.iss_valid = 1; bus.iss_waddr = 9;
    tick();
    bus.iss_valid = 0;
    bus.a_we = 1; bus.a_waddr = 4; bus.a_wdata = 32'h44;
    bus.b_valid = 1; bus.b_waddr = 9; bus.b_wdata = 32'hDEAD;
    tick();
    bus.b_valid = 0;
    bus.a_waddr = 9; bus.a_wdata = 32'h5555; bus.chk_waddr = 9;
    tick();
    bus.a_we = 0;
    checks++; if (bus.we !== 1'b1 || bus.waddr !== 5'd9 || bus.wdata !== 32'h5555) begin
      errors++; $display("FAIL waw_a: got we=%0b waddr=%0d wdata=%h want 1/9/5555", bus.we, bus.waddr, bus.wdata); end
    checks++; if (bus.err !== 1'b1 || bus.hazard !== 1'b0 || bus.b_ready !== 1'b1) begin
      errors++; $display("FAIL waw_state: got err=%0b hazard=%0b b_ready=%0b want 1/0/1", bus.err, bus.hazard, bus.b_ready); end
    tick();
    checks++; if (bus.we !== 1'b0 || bus.wdata !== 32'h5555 || bus.err !== 1'b1) begin
      errors++; $display("FAIL waw_dropped: got we=%0b wdata=%h err=%0b want 0/5555/1", bus.we, bus.wdata, bus.err); end
    bus.chk_waddr = 0;
  endtask

  task automatic test_reset_in_hold();
    bus.iss_valid = 1; bus.iss_waddr = 10; bus.chk_raddr1 = 10;
    tick();
    bus.iss_valid = 0;
    bus.a_we = 1; bus.a_waddr = 4; bus.a_wdata = 32'h66;
    bus.b_valid = 1; bus.b_waddr = 10; bus.b_wdata = 32'hABCD;
    tick();
    bus.a_we = 0; bus.b_valid = 0;
    checks++; if (bus.b_ready !== 1'b0 || bus.we !== 1'b1 || bus.hazard !== 1'b1) begin
      errors++; $display("FAIL hold_before_rst: got b_ready=%0b we=%0b hazard=%0b want 0/1/1", bus.b_ready, bus.we, bus.hazard); end
    rst = 0;
    #1;
    checks++; if (bus.we !== 1'b0 || bus.b_ready !== 1'b1 || bus.hazard !== 1'b0 || bus.err !== 1'b0) begin
      errors++; $display("FAIL async_rst: got we=%0b b_ready=%0b hazard=%0b err=%0b want 0/1/0/0",
                         bus.we, bus.b_ready, bus.hazard, bus.err); end
    tick();
    rst = 1;
    tick(); tick();
    checks++; if (bus.we !== 1'b0 || bus.hazard !== 1'b0) begin
      errors++; $display("FAIL rst_discard: got we=%0b hazard=%0b want 0/0", bus.we, bus.hazard); end
    bus.chk_raddr1 = 0;
  endtask

  task automatic test_set_clear_same();
    bus.iss_valid = 1; bus.iss_waddr = 3; bus.chk_raddr2 = 3;
    tick();
    bus.iss_valid = 0;
    bus.b_valid = 1; bus.b_waddr = 3; bus.b_wdata = 32'h3333;
`ifdef WB_BYPASS_EN
    bus.iss_valid = 1;
    tick();
`else
    tick();
    bus.b_valid = 0;
    bus.iss_valid = 1;
    tick();
`endif
    bus.b_valid = 0; bus.iss_valid = 0;
    checks++; if (bus.we !== 1'b1 || bus.waddr !== 5'd3 || bus.wdata !== 32'h3333) begin
      errors++; $display("FAIL setclr_write: got we=%0b waddr=%0d wdata=%h want 1/3/3333", bus.we, bus.waddr, bus.wdata); end
    checks++; if (bus.hazard !== 1'b1) begin errors++; $display("FAIL setclr_set_wins: got hazard=%0b want 1", bus.hazard); end
    bus.chk_raddr2 = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_a_write();
    test_reg_zero();
    test_b_write();
    test_starve();
    test_waw();
    test_reset_in_hold();
    test_set_clear_same();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
